// File: rtl/pshpul_seq_pkg.sv
// Shared constants for the stack push/pull sequencer.
//   - Sequencer states.
//   - Register-block codes (RN_*) driven on reg_addr.
//   - Postbyte mask bit positions (MB_*).
package pshpul_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_INC  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [3:0] RN_D  = 4'd0;
  localparam logic [3:0] RN_X  = 4'd1;
  localparam logic [3:0] RN_Y  = 4'd2;
  localparam logic [3:0] RN_U  = 4'd3;
  localparam logic [3:0] RN_S  = 4'd4;
  localparam logic [3:0] RN_PC = 4'd5;
  localparam logic [3:0] RN_A  = 4'd8;
  localparam logic [3:0] RN_B  = 4'd9;
  localparam logic [3:0] RN_CC = 4'd10;
  localparam logic [3:0] RN_DP = 4'd11;

  localparam logic [2:0] MB_CC = 3'd0;
  localparam logic [2:0] MB_A  = 3'd1;
  localparam logic [2:0] MB_B  = 3'd2;
  localparam logic [2:0] MB_DP = 3'd3;
  localparam logic [2:0] MB_X  = 3'd4;
  localparam logic [2:0] MB_Y  = 3'd5;
  localparam logic [2:0] MB_SP = 3'd6;
  localparam logic [2:0] MB_PC = 3'd7;

endpackage

// File: rtl/pshpul_pick.sv
// Combinational picker for the next register in a push/pull mask.
//   rem_i     : remaining mask bits
//   is_pull_i : 1 = pull (lowest bit first), 0 = push (highest bit first)
//   use_s_i   : stack in use; decides which pointer bit 6 names
//   idx_o     : selected bit index
//   code_o    : register code for that bit
//   wide_o    : selected register is 16 bits
//   any_o     : at least one bit remains
module pshpul_pick
  import pshpul_seq_pkg::*;
(
  input  logic [7:0] rem_i,
  input  logic       is_pull_i,
  input  logic       use_s_i,
  output logic [2:0] idx_o,
  output logic [3:0] code_o,
  output logic       wide_o,
  output logic       any_o
);

  always_comb begin
    idx_o = 3'd0;
    // Later hits overwrite earlier ones, so scan direction sets the priority.
    if (is_pull_i) begin
      for (int i = 7; i >= 0; i--) begin
        if (rem_i[i]) idx_o = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rem_i[i]) idx_o = 3'(i);
      end
    end
  end

  always_comb begin
    code_o = RN_CC;
    case (idx_o)
      MB_PC:   code_o = RN_PC;
      MB_SP:   code_o = use_s_i ? RN_U : RN_S;
      MB_Y:    code_o = RN_Y;
      MB_X:    code_o = RN_X;
      MB_DP:   code_o = RN_DP;
      MB_B:    code_o = RN_B;
      MB_A:    code_o = RN_A;
      default: code_o = RN_CC;
    endcase
  end

  assign wide_o = idx_o[2];
  assign any_o  = |rem_i;

endmodule

// File: rtl/pshpul_seq.sv
// Stack push/pull sequencer (PSHS/PSHU/PULS/PULU).
//   clk_in, reset_n        : clock, synchronous active-low reset
//   start/is_pull/use_s_in/mask : operation request, latched in IDLE
//   reg_data, reg_su       : register-block left path and selected stack pointer
//   mem_rdata, mem_ready   : memory read data and completion handshake
//   reg_addr, write_reg, data_w : register-block address / write port
//   inc_su, dec_su, use_s  : stack-pointer step strobes and stack select
//   mem_addr/mem_wdata/mem_we/mem_oe : byte memory port
//   busy, done             : status; done pulses for one cycle
module pshpul_seq
  import pshpul_seq_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_pull,
  input  logic        use_s_in,
  input  logic [7:0]  mask,
  input  logic [15:0] reg_data,
  input  logic [15:0] reg_su,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  reg_addr,
  output logic        write_reg,
  output logic [15:0] data_w,
  output logic        inc_su,
  output logic        dec_su,
  output logic        use_s,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        busy,
  output logic        done
);

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic       phase_q, phase_d;     // 0 = first byte of register, 1 = second
  logic       is_pull_q, is_pull_d;
  logic       use_s_q, use_s_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;

  logic       idle;
  logic [7:0] pick_rem;
  logic [2:0] pick_idx;
  logic [3:0] pick_code;
  logic       pick_wide;
  logic       pick_any;
  logic       last_byte;
  logic [7:0] rem_clr;
  state_e     byte_state;

  // In IDLE the picker looks at the incoming request so an empty mask is seen
  // before anything is latched.
  assign idle     = (state_q == ST_IDLE);
  assign pick_rem = idle ? mask : rem_q;

  pshpul_pick u_pick (
    .rem_i     (pick_rem),
    .is_pull_i (idle ? is_pull : is_pull_q),
    .use_s_i   (idle ? use_s_in : use_s_q),
    .idx_o     (pick_idx),
    .code_o    (pick_code),
    .wide_o    (pick_wide),
    .any_o     (pick_any)
  );

  assign last_byte  = !pick_wide || phase_q;
  assign rem_clr    = rem_q & ~(8'b1 << pick_idx);
  assign byte_state = is_pull_q ? ST_RD : ST_DEC;

  assign busy     = !idle;
  assign use_s    = use_s_q;
  assign mem_addr = reg_su;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    phase_d   = phase_q;
    is_pull_d = is_pull_q;
    use_s_d   = use_s_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    reg_addr  = 4'd0;
    write_reg = 1'b0;
    data_w    = 16'h0000;
    inc_su    = 1'b0;
    dec_su    = 1'b0;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_pull_d = is_pull;
          use_s_d   = use_s_in;
          rem_d     = mask;
          phase_d   = 1'b0;
          if (!pick_any)   state_d = ST_DONE;
          else if (is_pull) state_d = ST_RD;
          else              state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        reg_addr = pick_code;
        dec_su   = 1'b1;
        state_d  = ST_WR;
      end
      ST_WR: begin
        reg_addr  = pick_code;
        mem_we    = 1'b1;
        // Push sends the low byte first; 8-bit registers only ever use phase 0.
        mem_wdata = phase_q ? reg_data[15:8] : reg_data[7:0];
        if (mem_ready) begin
          if (last_byte) begin
            rem_d   = rem_clr;
            phase_d = 1'b0;
            state_d = (rem_clr != 8'h00) ? byte_state : ST_DONE;
          end else begin
            phase_d = 1'b1;
            state_d = byte_state;
          end
        end
      end
      ST_RD: begin
        reg_addr = pick_code;
        mem_oe   = 1'b1;
        if (mem_ready) begin
          // Pull fetches the high byte first for 16-bit registers.
          if (pick_wide && !phase_q) hi_d = mem_rdata;
          else                       lo_d = mem_rdata;
          state_d = ST_INC;
        end
      end
      ST_INC: begin
        reg_addr = pick_code;
        inc_su   = 1'b1;
        if (last_byte) begin
          write_reg = 1'b1;
          data_w    = pick_wide ? {hi_q, lo_q} : {8'h00, lo_q};
          rem_d     = rem_clr;
          phase_d   = 1'b0;
          state_d   = (rem_clr != 8'h00) ? byte_state : ST_DONE;
        end else begin
          phase_d = 1'b1;
          state_d = byte_state;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= 8'h00;
      phase_q   <= 1'b0;
      is_pull_q <= 1'b0;
      use_s_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      is_pull_q <= is_pull_d;
      use_s_q   <= use_s_d;
    end
  end

  // Pull holding bytes are pure data and are always rewritten before use.
  always_ff @(posedge clk_in) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

endmodule

// File: tb/tb_pshpul_seq.sv
module tb_pshpul_seq;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_pull = 1'b0;
  logic        use_s_in = 1'b1;
  logic [7:0]  mask = 8'h00;
  logic [15:0] reg_data;
  logic [15:0] reg_su;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [3:0]  reg_addr;
  logic        write_reg;
  logic [15:0] data_w;
  logic        inc_su, dec_su, use_s;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_oe, busy, done;

  always #5 clk_in = ~clk_in;

  pshpul_seq dut (
    .clk_in(clk_in), .reset_n(reset_n), .start(start), .is_pull(is_pull),
    .use_s_in(use_s_in), .mask(mask), .reg_data(reg_data), .reg_su(reg_su),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .reg_addr(reg_addr),
    .write_reg(write_reg), .data_w(data_w), .inc_su(inc_su), .dec_su(dec_su),
    .use_s(use_s), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_oe(mem_oe), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  // Register block and memory model
  logic [15:0] m_s = 16'h0, m_u = 16'h0, m_x = 16'h0, m_y = 16'h0, m_pc = 16'h0;
  logic [7:0]  m_a = 8'h0, m_b = 8'h0, m_cc = 8'h0, m_dp = 8'h0;
  logic [7:0]  mem [0:65535];
  int          stall_left = 0;
  int          we_cyc = 0, oe_cyc = 0, inc_cyc = 0, dec_cyc = 0, both_err = 0;
  int          wr_cnt = 0, addr_bad = 0;
  logic        we_prev = 1'b0;
  logic [15:0] we_addr_prev = 16'h0;
  logic [3:0]  last_code = 4'h0;
  logic [15:0] last_data = 16'h0;
  logic [23:0] wlog [$];
  logic [1:0]  ld_kind = 2'd0;
  logic [15:0] ld_addr = 16'h0, ld_val = 16'h0;

  always_comb begin
    case (reg_addr)
      4'd0:    reg_data = {m_a, m_b};
      4'd1:    reg_data = m_x;
      4'd2:    reg_data = m_y;
      4'd3:    reg_data = m_u;
      4'd4:    reg_data = m_s;
      4'd5:    reg_data = m_pc;
      4'd8:    reg_data = {8'h00, m_a};
      4'd9:    reg_data = {8'h00, m_b};
      4'd10:   reg_data = {8'h00, m_cc};
      4'd11:   reg_data = {8'h00, m_dp};
      default: reg_data = 16'h0000;
    endcase
  end

  assign reg_su    = use_s ? m_s : m_u;
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (stall_left == 0);

  always @(posedge clk_in) begin
    if (ld_kind == 2'd1) begin
      case (ld_addr[3:0])
        4'd1: m_x <= ld_val;   4'd2: m_y <= ld_val;   4'd3: m_u <= ld_val;
        4'd4: m_s <= ld_val;   4'd5: m_pc <= ld_val;  4'd8: m_a <= ld_val[7:0];
        4'd9: m_b <= ld_val[7:0]; 4'd10: m_cc <= ld_val[7:0]; 4'd11: m_dp <= ld_val[7:0];
        default: ;
      endcase
    end else if (ld_kind == 2'd2) begin
      mem[ld_addr] <= ld_val[7:0];
    end else if (ld_kind == 2'd3) begin
      stall_left <= int'(ld_val);
    end
    if (dec_su) begin
      dec_cyc <= dec_cyc + 1;
      if (use_s) m_s <= m_s - 16'd1; else m_u <= m_u - 16'd1;
    end
    if (inc_su) begin
      inc_cyc <= inc_cyc + 1;
      if (use_s) m_s <= m_s + 16'd1; else m_u <= m_u + 16'd1;
    end
    if (inc_su && dec_su) both_err <= both_err + 1;
    if (mem_we) begin
      we_cyc <= we_cyc + 1;
      if (we_prev && mem_addr != we_addr_prev) addr_bad <= addr_bad + 1;
    end
    we_prev      <= mem_we;
    we_addr_prev <= mem_addr;
    if (mem_oe) oe_cyc <= oe_cyc + 1;
    if ((mem_we || mem_oe) && stall_left != 0) stall_left <= stall_left - 1;
    if (mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (write_reg) begin
      wr_cnt    <= wr_cnt + 1;
      last_code <= reg_addr;
      last_data <= data_w;
      case (reg_addr)
        4'd0: begin m_a <= data_w[15:8]; m_b <= data_w[7:0]; end
        4'd1: m_x <= data_w;   4'd2: m_y <= data_w;   4'd3: m_u <= data_w;
        4'd4: m_s <= data_w;   4'd5: m_pc <= data_w;  4'd8: m_a <= data_w[7:0];
        4'd9: m_b <= data_w[7:0]; 4'd10: m_cc <= data_w[7:0]; 4'd11: m_dp <= data_w[7:0];
        default: ;
      endcase
    end
  end

  task automatic poke(input logic [1:0] k, input logic [15:0] a, input logic [15:0] v);
    @(negedge clk_in);
    ld_kind = k; ld_addr = a; ld_val = v;
    @(posedge clk_in); #1;
    ld_kind = 2'd0;
  endtask

  // Runs one operation; cyc = cycle (1 = first after the start edge) in which done is seen.
  // A nonzero spurious value re-asserts start in that busy cycle.
  task automatic run_op(input logic pull, input logic sel_s, input logic [7:0] m,
                        input int spurious, output int cyc);
    @(negedge clk_in);
    is_pull = pull; use_s_in = sel_s; mask = m; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == spurious) begin start = 1'b1; mask = 8'hFF; is_pull = ~pull; end
      else start = 1'b0;
      @(posedge clk_in); #1;
      cyc++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      tests++; fails++;
      $display("FAIL op_timeout: done=%b required 1 within 200 cycles", done);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %b want 0", done); end
    tests++; if ({write_reg, inc_su, dec_su, mem_we, mem_oe} !== 5'b0)
      begin fails++; $display("FAIL rst_strobes: got %b want 00000", {write_reg, inc_su, dec_su, mem_we, mem_oe}); end
    tests++; if (mem_wdata !== 8'h00) begin fails++; $display("FAIL rst_wdata: got %h want 00", mem_wdata); end
    tests++; if (data_w !== 16'h0000) begin fails++; $display("FAIL rst_data_w: got %h want 0000", data_w); end
    tests++; if (reg_addr !== 4'h0)  begin fails++; $display("FAIL rst_reg_addr: got %h want 0", reg_addr); end
    tests++; if (use_s !== 1'b1)     begin fails++; $display("FAIL rst_use_s: got %b want 1", use_s); end
    @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  task automatic test_push_ab();
    int cyc, base;
    poke(2'd1, 16'd4, 16'h0F00);
    poke(2'd1, 16'd8, 16'h0012);
    poke(2'd1, 16'd9, 16'h0034);
    base = wlog.size();
    run_op(1'b0, 1'b1, 8'h06, 0, cyc);
    tests++; if (cyc !== 5) begin fails++; $display("FAIL pshs_ab_latency: got %0d want 5", cyc); end
    tests++; if (wlog.size() - base !== 2) begin fails++; $display("FAIL pshs_ab_count: got %0d want 2", wlog.size() - base); end
    if (wlog.size() >= base + 2) begin
      tests++; if (wlog[base] !== {16'h0EFF, 8'h34}) begin fails++; $display("FAIL pshs_ab_w0: got %h want 0eff34", wlog[base]); end
      tests++; if (wlog[base+1] !== {16'h0EFE, 8'h12}) begin fails++; $display("FAIL pshs_ab_w1: got %h want 0efe12", wlog[base+1]); end
    end
    tests++; if (m_s !== 16'h0EFE) begin fails++; $display("FAIL pshs_ab_s: got %h want 0efe", m_s); end
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL pshs_ab_idle: done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_pull_x();
    int cyc, base, w0;
    poke(2'd1, 16'd3, 16'h0E00);
    poke(2'd1, 16'd1, 16'h0000);
    poke(2'd2, 16'h0E00, 16'h00AB);
    poke(2'd2, 16'h0E01, 16'h00CD);
    base = wlog.size(); w0 = wr_cnt;
    run_op(1'b1, 1'b0, 8'h10, 0, cyc);
    tests++; if (cyc !== 5) begin fails++; $display("FAIL pulu_x_latency: got %0d want 5", cyc); end
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL pulu_x_wrcnt: got %0d want 1", wr_cnt - w0); end
    tests++; if (last_code !== 4'd1) begin fails++; $display("FAIL pulu_x_code: got %0d want 1", last_code); end
    tests++; if (last_data !== 16'hABCD) begin fails++; $display("FAIL pulu_x_data: got %h want abcd", last_data); end
    tests++; if (m_u !== 16'h0E02) begin fails++; $display("FAIL pulu_x_u: got %h want 0e02", m_u); end
    tests++; if (wlog.size() !== base) begin fails++; $display("FAIL pulu_x_nowrite: got %0d writes want 0", wlog.size() - base); end
  endtask

  task automatic test_push_all();
    int cyc, base, b0;
    logic [7:0] exp_b [12];
    exp_b = '{8'hA2, 8'hA1, 8'hB2, 8'hB1, 8'hC2, 8'hC1, 8'hD2, 8'hD1, 8'hE1, 8'hF2, 8'hF3, 8'hF4};
    poke(2'd1, 16'd4, 16'h2000);  poke(2'd1, 16'd5, 16'hA1A2);
    poke(2'd1, 16'd3, 16'hB1B2);  poke(2'd1, 16'd2, 16'hC1C2);
    poke(2'd1, 16'd1, 16'hD1D2);  poke(2'd1, 16'd11, 16'h00E1);
    poke(2'd1, 16'd9, 16'h00F2);  poke(2'd1, 16'd8, 16'h00F3);
    poke(2'd1, 16'd10, 16'h00F4);
    base = wlog.size(); b0 = both_err;
    run_op(1'b0, 1'b1, 8'hFF, 0, cyc);
    tests++; if (cyc !== 25) begin fails++; $display("FAIL pshs_all_latency: got %0d want 25", cyc); end
    tests++; if (wlog.size() - base !== 12) begin fails++; $display("FAIL pshs_all_count: got %0d want 12", wlog.size() - base); end
    if (wlog.size() >= base + 12) begin
      for (int i = 0; i < 12; i++) begin
        tests++;
        if (wlog[base+i] !== {16'h1FFF - 16'(i), exp_b[i]}) begin
          fails++; $display("FAIL pshs_all_w%0d: got %h want %h", i, wlog[base+i], {16'h1FFF - 16'(i), exp_b[i]});
        end
      end
    end
    tests++; if (m_s !== 16'h1FF4) begin fails++; $display("FAIL pshs_all_s: got %h want 1ff4", m_s); end
    tests++; if (both_err !== b0) begin fails++; $display("FAIL pshs_all_both_strobes: got %0d want 0", both_err - b0); end
  endtask

  task automatic test_zero_mask();
    int cyc, we0, oe0, in0, de0, w0;
    we0 = we_cyc; oe0 = oe_cyc; in0 = inc_cyc; de0 = dec_cyc; w0 = wr_cnt;
    run_op(1'b0, 1'b1, 8'h00, 0, cyc);
    tests++; if (cyc !== 1) begin fails++; $display("FAIL zero_latency: got %0d want 1", cyc); end
    tests++; if (we_cyc - we0 !== 0 || oe_cyc - oe0 !== 0)
      begin fails++; $display("FAIL zero_bus: we=%0d oe=%0d want 0 0", we_cyc - we0, oe_cyc - oe0); end
    tests++; if (inc_cyc - in0 !== 0 || dec_cyc - de0 !== 0 || wr_cnt - w0 !== 0)
      begin fails++; $display("FAIL zero_strobes: inc=%0d dec=%0d wr=%0d want 0 0 0", inc_cyc - in0, dec_cyc - de0, wr_cnt - w0); end
  endtask

  task automatic test_wait();
    int cyc, base, we0, ab0;
    poke(2'd1, 16'd4, 16'h3000);
    poke(2'd1, 16'd8, 16'h005A);
    poke(2'd3, 16'h0, 16'd3);
    base = wlog.size(); we0 = we_cyc; ab0 = addr_bad;
    run_op(1'b0, 1'b1, 8'h02, 0, cyc);
    tests++; if (cyc !== 6) begin fails++; $display("FAIL wait_latency: got %0d want 6", cyc); end
    tests++; if (we_cyc - we0 !== 4) begin fails++; $display("FAIL wait_we_cycles: got %0d want 4", we_cyc - we0); end
    tests++; if (addr_bad !== ab0) begin fails++; $display("FAIL wait_addr_stable: got %0d changes want 0", addr_bad - ab0); end
    tests++; if (wlog.size() - base !== 1) begin fails++; $display("FAIL wait_count: got %0d want 1", wlog.size() - base); end
    if (wlog.size() >= base + 1) begin
      tests++; if (wlog[base] !== {16'h2FFF, 8'h5A}) begin fails++; $display("FAIL wait_w0: got %h want 2fff5a", wlog[base]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, base;
    poke(2'd1, 16'd4, 16'h3100);
    poke(2'd1, 16'd9, 16'h0077);
    base = wlog.size();
    run_op(1'b0, 1'b1, 8'h04, 2, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL busy_start_latency: got %0d want 3", cyc); end
    tests++; if (wlog.size() - base !== 1) begin fails++; $display("FAIL busy_start_count: got %0d want 1", wlog.size() - base); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_idle: busy=%b want 0", busy); end
    base = wlog.size();
    run_op(1'b0, 1'b1, 8'h04, 0, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL b2b_latency: got %0d want 3", cyc); end
    if (wlog.size() >= base + 1) begin
      tests++; if (wlog[base] !== {16'h30FE, 8'h77}) begin fails++; $display("FAIL b2b_w0: got %h want 30fe77", wlog[base]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, base;
    poke(2'd1, 16'd4, 16'h4000);
    poke(2'd1, 16'd5, 16'hA1A2);
    poke(2'd1, 16'd3, 16'hB1B2);
    base = wlog.size();
    @(negedge clk_in);
    is_pull = 1'b0; use_s_in = 1'b1; mask = 8'hC0; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    @(negedge clk_in);
    reset_n = 1'b0;
    @(posedge clk_in); #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_rst_status: busy=%b done=%b want 0 0", busy, done); end
    tests++; if ({mem_we, mem_oe, dec_su, inc_su, write_reg} !== 5'b0)
      begin fails++; $display("FAIL mid_rst_strobes: got %b want 00000", {mem_we, mem_oe, dec_su, inc_su, write_reg}); end
    tests++; if (reg_addr !== 4'h0 || use_s !== 1'b1) begin fails++; $display("FAIL mid_rst_regs: reg_addr=%h use_s=%b want 0 1", reg_addr, use_s); end
    tests++; if (m_s !== 16'h3FFE) begin fails++; $display("FAIL mid_rst_s: got %h want 3ffe", m_s); end
    tests++; if (wlog.size() - base !== 2) begin fails++; $display("FAIL mid_rst_count: got %0d want 2", wlog.size() - base); end
    @(negedge clk_in);
    reset_n = 1'b1;
    poke(2'd1, 16'd8, 16'h0066);
    base = wlog.size();
    run_op(1'b0, 1'b1, 8'h02, 0, cyc);
    tests++; if (cyc !== 3) begin fails++; $display("FAIL post_rst_latency: got %0d want 3", cyc); end
    if (wlog.size() >= base + 1) begin
      tests++; if (wlog[base] !== {16'h3FFD, 8'h66}) begin fails++; $display("FAIL post_rst_w0: got %h want 3ffd66", wlog[base]); end
    end else begin
      tests++; fails++; $display("FAIL post_rst_count: got %0d want 1", wlog.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_push_ab();
    test_pull_x();
    test_push_all();
    test_zero_mask();
    test_wait();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
